pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the OpenMIPS IF stage. It supplies the instruction-memory fetch address and chip enable and advances by a configurable step each cycle. It accepts branch redirects from ID and exception redirects from CTRL. A branch that arrives while IF is stalled is captured and applied when the stall releases, so the redirect is not lost.

## Interface

- ADDR_W, 32: width of the PC and all address ports.
- RESET_VECTOR, 32'h00000000: first fetch address after reset (low ADDR_W bits used).
- STEP, 4: sequential increment in bytes. Must be a power of two, 1..2^(ADDR_W-1).
- STALL_W, 6: width of the pipeline stall vector. Only bit 0 (IF) is used.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- stall  in  STALL_W  stall vector from CTRL; stall[0]=1 holds IF.
- flush  in  1  exception/ERET redirect from CTRL; highest priority.
- new_pc  in  ADDR_W  redirect target, valid when flush=1.
- branch_flag_i  in  1  ID reports a taken branch/jump.
- branch_target_address_i  in  ADDR_W  branch target, valid when branch_flag_i=1.
- pc  out  ADDR_W  fetch address (registered).
- ce  out  1  instruction-memory enable (registered).
- redirect_pending_o  out  1  a captured branch target is waiting for the stall to release.
- pc_misaligned_o  out  1  ce=1 and pc is not a multiple of STEP (combinational from pc).

## Operation

- State:
  - ce
  - pc
  - pend_valid
  - pend_addr (ADDR_W)
- Reset (rst=0 at an edge): ce<=0, pc<=RESET_VECTOR, pend_valid<=0, pend_addr<=0.
- ce: at each edge with rst=1, ce<=1. ce therefore rises one cycle after reset release.
- pc update when rst=1, in priority order:
  1. ce=0: pc<=RESET_VECTOR. flush, branch and stall are all ignored, and pending stays clear.
  2. flush=1: pc<=new_pc and pend_valid<=0, regardless of stall or branch. A simultaneous branch is dropped.
  3. stall[0]=1: pc holds. If branch_flag_i=1, then pend_valid<=1 and pend_addr<=branch_target_address_i. A later branch during the same stall overwrites the earlier one (latest wins). With no branch, pending is unchanged.
  4. stall[0]=0 and branch_flag_i=1: pc<=branch_target_address_i and pend_valid<=0. A live branch overrides a stale pending one.
  5. stall[0]=0 and pend_valid=1: pc<=pend_addr and pend_valid<=0.
  6. Otherwise: pc<=pc+STEP, truncated to ADDR_W bits, so it wraps 2^ADDR_W-STEP -> 0 with no flag.
- Outputs:
  - redirect_pending_o = pend_valid.
  - pc_misaligned_o = ce & (pc[log2(STEP)-1:0] != 0). It is always 0 when STEP=1.
- The block performs no alignment correction. Misaligned targets are passed through, and the flag is raised for the exception logic.

## Timing

- All outputs are registered except pc_misaligned_o, which is a pure decode of the registered pc and ce.
- Reset values:
  - pc=RESET_VECTOR
  - ce=0
  - redirect_pending_o=0
  - pc_misaligned_o=0
- Reset release:
  - Edge E0 samples rst=1: ce=1, pc=RESET_VECTOR.
  - Edge E1: pc=RESET_VECTOR+STEP, if unstalled.
  - RESET_VECTOR is therefore presented with ce=1 for at least one cycle.
- Redirect latency: branch or flush sampled at edge N takes effect on pc after edge N (one cycle).
- Pending branch: captured at the stalled edge, and appears on pc at the first edge where stall[0]=0 (unless a flush or a live branch overrides it).
- Reset mid-operation: one edge with rst=0 clears ce, pc and pending in the same edge. The next cycle fetches nothing (ce=0).
- Flush during the ce=0 cycle after reset is ignored.

## Test plan

- **Reset and sequential fetch:** hold rst=0 for 3 cycles, then release with RESET_VECTOR=32'hBFC00000.
  - ce=0 during reset.
  - Then pc=BFC00000 with ce=1, followed by BFC00004 and BFC00008.
- **Stall hold:** assert stall[0]=1 for 3 cycles at pc=0x20.
  - pc stays 0x20.
  - Sequential fetch resumes at 0x24.
- **Branch during stall:** stall[0]=1 while branch_flag_i=1 with target 0x100 for one cycle; release the stall 2 cycles later.
  - redirect_pending_o=1 until release.
  - pc=0x100 on the release edge, then redirect_pending_o=0.
- **Priorities:** at one edge, flush=1 with new_pc=0x180, branch with target 0x40, and stall[0]=1.
  - pc=0x180 and the pending latch is cleared.
  - Separately: a pending target of 0x100 with a live branch to 0x200 at release gives pc=0x200.
- **Wrap and misalign:**
  - ADDR_W=32, STEP=4, pc=FFFFFFFC, no stall: next pc=00000000.
  - Branch to 0x102: pc=0x102 and pc_misaligned_o=1.
- **Reset mid-operation:** set a pending branch, then pulse rst=0 for one edge.
  - pc=RESET_VECTOR, ce=0, redirect_pending_o=0.
  - ce=1 on the following edge.

Source files
------------

// File: rtl/pc_gen_if.sv
// Purpose : fetch-address bundle between the IF PC generator and its CTRL/ID/imem neighbours.
// Latency : none, wires only.
// Backpressure : stall[0] from CTRL holds the PC; there is no ready signal back to CTRL.
interface pc_gen_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned STALL_W = 6
);
  // Redirect and stall inputs to the PC generator
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;

  // Fetch request and status outputs of the PC generator
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redirect_pending_o;
  logic               pc_misaligned_o;

  // Side owned by the PC generator
  modport master (
    input  stall,
    input  flush,
    input  new_pc,
    input  branch_flag_i,
    input  branch_target_address_i,
    output pc,
    output ce,
    output redirect_pending_o,
    output pc_misaligned_o
  );

  // Side owned by CTRL/ID/instruction memory
  modport slave (
    output stall,
    output flush,
    output new_pc,
    output branch_flag_i,
    output branch_target_address_i,
    input  pc,
    input  ce,
    input  redirect_pending_o,
    input  pc_misaligned_o
  );
endinterface

// File: rtl/pc_gen.sv
// Purpose : IF-stage program counter with flush/branch redirect and a stall-time branch latch.
// Latency : redirects sampled at edge N appear on pc after edge N; pc/ce are registered.
// Backpressure : stall[0] holds pc; a branch seen while stalled is held until the stall drops.
module pc_gen #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned STALL_W      = 6
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.master  bus
);

  // Boot address trimmed/extended to the PC width.
  localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_VECTOR);
  // Sequential increment and the low-bit mask used to spot misaligned fetches.
  // STEP is a power of two, so STEP-1 selects exactly the bits that must be zero.
  localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);

  logic              ce_q,         ce_d;
  logic [ADDR_W-1:0] pc_q,         pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;

  logic              if_stall;
  // Only the IF bit of the stall vector matters here; the rest is deliberately ignored.
  logic              stall_unused;

  assign if_stall     = bus.stall[0];
  assign stall_unused = ^bus.stall;

  // Next-state selection, highest priority first:
  // not yet fetching -> flush -> stalled (capture branch) -> live branch -> pending branch -> step.
  always_comb begin
    ce_d         = 1'b1;
    pc_d         = pc_q + STEP_INC;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    if (!ce_q) begin
      // First cycle out of reset: present the boot vector, ignore all redirects.
      pc_d         = RST_PC;
      pend_valid_d = 1'b0;
    end else if (bus.flush) begin
      // Exception/ERET wins over everything; any latched branch is now stale.
      pc_d         = bus.new_pc;
      pend_valid_d = 1'b0;
    end else if (if_stall) begin
      // Hold the fetch address; remember the most recent branch seen during the stall.
      pc_d = pc_q;
      if (bus.branch_flag_i) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = bus.branch_target_address_i;
      end
    end else if (bus.branch_flag_i) begin
      // A branch resolved this cycle is newer than anything latched earlier.
      pc_d         = bus.branch_target_address_i;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      // Stall just released: replay the branch that arrived while stalled.
      pc_d         = pend_addr_q;
      pend_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ce_q         <= 1'b0;
      pc_q         <= RST_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      ce_q         <= ce_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  // Registered outputs plus a pure decode of the registered pc for the exception logic.
  assign bus.pc                 = pc_q;
  assign bus.ce                 = ce_q;
  assign bus.redirect_pending_o = pend_valid_q;
  assign bus.pc_misaligned_o    = ce_q & (|(pc_q & STEP_MASK));

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic clk;
  logic rst;

  pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

  pc_gen #(
    .ADDR_W      (32),
    .RESET_VECTOR(32'hBFC0_0000),
    .STEP        (4),
    .STALL_W     (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        ce;
    logic [31:0] pc;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the state expected after the next rising edge.
  task automatic drive(input string tag, input logic r, input logic s, input logic f,
                       input logic [31:0] np, input logic b, input logic [31:0] bt,
                       input logic ece, input logic [31:0] epc, input logic epend, input logic emis);
    exp_t e;
    @(negedge clk);
    rst                         = r;
    bus.stall                   = {5'b0, s};
    bus.flush                   = f;
    bus.new_pc                  = np;
    bus.branch_flag_i           = b;
    bus.branch_target_address_i = bt;
    e.tag  = tag;
    e.ce   = ece;
    e.pc   = epc;
    e.pend = epend;
    e.mis  = emis;
    sb.push_back(e);
  endtask

  // Compare DUT state against the queued expectation shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ce"},   {31'b0, bus.ce},                 {31'b0, e.ce});
      chk({e.tag, ".pc"},   bus.pc,                          e.pc);
      chk({e.tag, ".pend"}, {31'b0, bus.redirect_pending_o}, {31'b0, e.pend});
      chk({e.tag, ".mis"},  {31'b0, bus.pc_misaligned_o},    {31'b0, e.mis});
    end
  end

  localparam logic [31:0] RV = 32'hBFC0_0000;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst                         = 1'b0;
    bus.stall                   = '0;
    bus.flush                   = 1'b0;
    bus.new_pc                  = '0;
    bus.branch_flag_i           = 1'b0;
    bus.branch_target_address_i = '0;

    // Reset held for three edges, then sequential fetch from the boot vector.
    for (int i = 0; i < 3; i++)
      drive("rst_hold", 0, 0, 0, 0, 0, 0, 0, RV, 0, 0);
    drive("rst_rel_e0", 1, 0, 0, 0, 0, 0, 1, RV, 0, 0);
    drive("seq_e1",     1, 0, 0, 0, 0, 0, 1, RV + 4, 0, 0);
    drive("seq_e2",     1, 0, 0, 0, 0, 0, 1, RV + 8, 0, 0);

    // Stall hold at 0x20.
    drive("flush_20", 1, 0, 1, 32'h20, 0, 0, 1, 32'h20, 0, 0);
    for (int i = 0; i < 3; i++)
      drive("stall_hold", 1, 1, 0, 0, 0, 0, 1, 32'h20, 0, 0);
    drive("stall_rel", 1, 0, 0, 0, 0, 0, 1, 32'h24, 0, 0);

    // Branch captured during stall, replayed on release.
    drive("br_in_stall", 1, 1, 0, 0, 1, 32'h100, 1, 32'h24, 1, 0);
    drive("pend_wait1",  1, 1, 0, 0, 0, 0,       1, 32'h24, 1, 0);
    drive("pend_wait2",  1, 1, 0, 0, 0, 0,       1, 32'h24, 1, 0);
    drive("pend_rel",    1, 0, 0, 0, 0, 0,       1, 32'h100, 0, 0);
    drive("pend_after",  1, 0, 0, 0, 0, 0,       1, 32'h104, 0, 0);

    // Latest branch during one stall wins.
    drive("latest_a",   1, 1, 0, 0, 1, 32'h300, 1, 32'h104, 1, 0);
    drive("latest_b",   1, 1, 0, 0, 1, 32'h340, 1, 32'h104, 1, 0);
    drive("latest_rel", 1, 0, 0, 0, 0, 0,       1, 32'h340, 0, 0);

    // Flush beats stall and branch, and clears the pending latch.
    drive("prio_pend",  1, 1, 0, 0,       1, 32'h100, 1, 32'h340, 1, 0);
    drive("prio_flush", 1, 1, 1, 32'h180, 1, 32'h40,  1, 32'h180, 0, 0);
    drive("prio_after", 1, 0, 0, 0,       0, 0,       1, 32'h184, 0, 0);

    // Live branch at release overrides a stale pending target.
    drive("live_pend", 1, 1, 0, 0, 1, 32'h100, 1, 32'h184, 1, 0);
    drive("live_wait", 1, 1, 0, 0, 0, 0,       1, 32'h184, 1, 0);
    drive("live_rel",  1, 0, 0, 0, 1, 32'h200, 1, 32'h200, 0, 0);
    drive("live_seq",  1, 0, 0, 0, 0, 0,       1, 32'h204, 0, 0);

    // Wrap at the top of the address space.
    drive("wrap_set", 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    drive("wrap",     1, 0, 0, 0,             0, 0, 1, 32'h0000_0000, 0, 0);

    // Misaligned target passes through and raises the flag.
    drive("mis_br",    1, 0, 0, 0,      1, 32'h102, 1, 32'h102, 0, 1);
    drive("mis_seq",   1, 0, 0, 0,      0, 0,       1, 32'h106, 0, 1);
    drive("mis_clear", 1, 0, 1, 32'h10, 0, 0,       1, 32'h10,  0, 0);

    // Reset mid-operation with a pending branch; redirects ignored in the ce=0 cycle.
    drive("mid_pend", 1, 1, 0, 0,      1, 32'h500, 1, 32'h10,   1, 0);
    drive("mid_rst",  0, 1, 0, 0,      0, 0,       0, RV,       0, 0);
    drive("mid_ce0",  1, 0, 1, 32'h80, 1, 32'h90,  1, RV,       0, 0);
    drive("mid_seq",  1, 0, 0, 0,      0, 0,       1, RV + 4,   0, 0);

    // Let the last expectations drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    chk("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
